pbit_field_update: RTL and testbench

PBIT_FIELD_UPDATE -- requirements
Module: pbit_field_update

---
 rtl/pbit_field_update.sv | 155 +++++++++++++++
 tb/tb_pbit_field_update.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbit_field_update.sv
// Row-serial p-bit update: accumulates the row's weights into a local field, adds the bias and compares against an LFSR draw.
// Optional: define PBIT_ACC_SAT_EN to make every accumulator add saturate instead of wrapping.
module pbit_field_update #(
   parameter int                   NUM_PBITS   = 16,
   parameter int                   VAL_WIDTH   = 8,
   parameter int                   INDEX_WIDTH = 4,
   parameter int                   ACC_WIDTH   = 16,
   parameter logic [15:0]          LFSR_SEED   = 16'hACE1,
   parameter logic [NUM_PBITS-1:0] INIT_STATE  = '0
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               data_valid,
   input  logic signed [VAL_WIDTH-1:0]        value,
   input  logic        [INDEX_WIDTH-1:0]      index,
   input  logic signed [7:0]                  h,
   input  logic                               load_done,
   input  logic [$clog2(NUM_PBITS+1)-1:0]     row,
   output logic                               compute_done,
   output logic [NUM_PBITS-1:0]               m
);

   // Two guard bits hold any single add exactly before wrap or saturation.
   localparam int EXT_WIDTH = ACC_WIDTH + 2;
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   localparam logic signed [ACC_WIDTH-1:0] ACT_MAX = ACC_WIDTH'(127);
   localparam logic signed [ACC_WIDTH-1:0] ACT_MIN = ACC_WIDTH'(-128);

   typedef enum logic [2:0] {
      IDLE,
      ACCUM,
      ADD_H,
      COMPARE,
      DONE
   } state_t;

   state_t                      state_q;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic                        computeDone_q;
   logic [NUM_PBITS-1:0]        m_q;
   logic [15:0]                 lfsr_q;

   logic                        idxHit;
   logic                        mIdx;
   logic signed [EXT_WIDTH-1:0] valueExt;
   logic signed [EXT_WIDTH-1:0] beatTerm;
   logic signed [EXT_WIDTH-1:0] hExt;
   logic signed [ACC_WIDTH-1:0] accBeat_d;
   logic signed [ACC_WIDTH-1:0] accBias_d;
   logic signed [7:0]           act;
   logic                        newBit;
   logic [NUM_PBITS-1:0]        m_d;
   logic [15:0]                 lfsr_d;

   function automatic logic signed [ACC_WIDTH-1:0] addAcc(
      input logic signed [ACC_WIDTH-1:0] base,
      input logic signed [EXT_WIDTH-1:0] term
   );
      logic signed [EXT_WIDTH-1:0] sum;
      sum = {{2{base[ACC_WIDTH-1]}}, base} + term;
`ifdef PBIT_ACC_SAT_EN
      if (sum[EXT_WIDTH-1:ACC_WIDTH-1] != {3{sum[EXT_WIDTH-1]}}) begin
         return sum[EXT_WIDTH-1] ? ACC_MIN : ACC_MAX;
      end
`endif
      return sum[ACC_WIDTH-1:0];
   endfunction

   // Datapath: the signed beat contribution, the bias add, the clamp/compare and the next LFSR value.
   always_comb begin
      idxHit = 1'b0;
      mIdx   = 1'b0;
      for (int i = 0; i < NUM_PBITS; i++) begin
         if (32'(index) == i) begin
            idxHit = 1'b1;
            mIdx   = m_q[i];
         end
      end

      valueExt  = {{(EXT_WIDTH-VAL_WIDTH){value[VAL_WIDTH-1]}}, value};
      beatTerm  = idxHit ? (mIdx ? valueExt : -valueExt) : '0;
      accBeat_d = addAcc(acc_q, beatTerm);

      hExt      = {{(EXT_WIDTH-8){h[7]}}, h};
      accBias_d = addAcc(acc_q, hExt);

      if (acc_q > ACT_MAX) begin
         act = 8'h7F;
      end else if (acc_q < ACT_MIN) begin
         act = 8'h80;
      end else begin
         act = acc_q[7:0];
      end
      newBit = (act > $signed(lfsr_q[7:0]));

      m_d = m_q;
      for (int i = 0; i < NUM_PBITS; i++) begin
         if (32'(row) == i) begin
            m_d[i] = newBit;
         end
      end

      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
   end

   // Row sequencer; the LFSR free-runs so every row sees a fresh draw.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         acc_q         <= '0;
         computeDone_q <= 1'b0;
         m_q           <= INIT_STATE;
         lfsr_q        <= LFSR_SEED;
      end else begin
         lfsr_q        <= lfsr_d;
         computeDone_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!load_done) begin
                  acc_q   <= '0;
                  state_q <= ACCUM;
               end
            end
            ACCUM: begin
               if (data_valid) begin
                  acc_q <= accBeat_d;
               end
               if (load_done) begin
                  state_q <= ADD_H;
               end
            end
            ADD_H: begin
               acc_q   <= accBias_d;
               state_q <= COMPARE;
            end
            COMPARE: begin
               m_q           <= m_d;
               computeDone_q <= 1'b1;
               state_q       <= DONE;
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign compute_done = computeDone_q;
   assign m            = m_q;

endmodule

// File: tb/tb_pbit_field_update.sv
// Directed bench for pbit_field_update: a 16-bit-accumulator DUT and an 8-bit-accumulator DUT share one stimulus stream.
// Build with or without PBIT_ACC_SAT_EN; the narrow DUT's expectations follow the macro.
module tb_pbit_field_update;

   localparam int          NUM_PBITS = 16;
   localparam int          ROW_WIDTH = $clog2(NUM_PBITS+1);
   localparam logic [15:0] INIT_M    = 16'h0003;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b1;
   logic                 data_valid = 1'b0;
   logic signed [7:0]    value = '0;
   logic [3:0]           index = '0;
   logic signed [7:0]    h = '0;
   logic                 load_done = 1'b0;
   logic [ROW_WIDTH-1:0] row = '0;
   logic                 compute_done;
   logic                 compute_done8;
   logic [15:0]          m;
   logic [15:0]          m8;

   logic [15:0] lfsrModel;
   logic [15:0] lfsrPrev;
   logic [15:0] mModel;
   logic [15:0] m8Model;
   int          assertCount = 0;
   int          failCount = 0;

   always #5 clk = ~clk;

   pbit_field_update #(
      .NUM_PBITS(16), .VAL_WIDTH(8), .INDEX_WIDTH(4), .ACC_WIDTH(16),
      .LFSR_SEED(16'hACE1), .INIT_STATE(INIT_M)
   ) dut (
      .clk(clk), .reset_n(reset_n), .data_valid(data_valid), .value(value),
      .index(index), .h(h), .load_done(load_done), .row(row),
      .compute_done(compute_done), .m(m)
   );

   pbit_field_update #(
      .NUM_PBITS(16), .VAL_WIDTH(8), .INDEX_WIDTH(4), .ACC_WIDTH(8),
      .LFSR_SEED(16'hACE1), .INIT_STATE(INIT_M)
   ) dut8 (
      .clk(clk), .reset_n(reset_n), .data_valid(data_valid), .value(value),
      .index(index), .h(h), .load_done(load_done), .row(row),
      .compute_done(compute_done8), .m(m8)
   );

   // Reference Fibonacci LFSR (x^16+x^14+x^13+x^11+1); lfsrPrev holds the draw used by the commit edge just passed.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsrModel <= 16'hACE1;
         lfsrPrev  <= 16'hACE1;
      end else begin
         lfsrPrev  <= lfsrModel;
         lfsrModel <= (lfsrModel >> 1) |
                      (16'((lfsrModel ^ (lfsrModel >> 2) ^ (lfsrModel >> 3) ^ (lfsrModel >> 5)) & 16'h0001) << 15);
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic expBit(input int actVal, input logic [15:0] draw);
      logic signed [7:0] s;
      s = draw[7:0];
      return actVal > int'(s);
   endfunction

   task automatic applyReset();
      data_valid = 1'b0;
      load_done  = 1'b0;
      reset_n    = 1'b0;
      #12;
      reset_n = 1'b1;
      @(posedge clk); #1;
      mModel  = INIT_M;
      m8Model = INIT_M;
   endtask

   task automatic startRow(input logic [ROW_WIDTH-1:0] r, input logic signed [7:0] hv);
      data_valid = 1'b0;
      load_done  = 1'b0;
      row        = r;
      h          = hv;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic sendBeat(input logic [3:0] idx, input logic signed [7:0] val);
      data_valid = 1'b1;
      index      = idx;
      value      = val;
      @(posedge clk); #1;
      data_valid = 1'b0;
   endtask

   // lat counts edges after the load_done sample until compute_done is visible; 2 means it is captured on the 3rd edge.
   task automatic finishRow(output int lat, output logic [15:0] used);
      load_done = 1'b1;
      @(posedge clk); #1;
      data_valid = 1'b0;
      lat = 0;
      while (compute_done !== 1'b1 && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      used = lfsrPrev;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1;
      assertCount++;
      if (m !== INIT_M) begin
         failCount++; $display("[TB] FAIL reset_m: got %h expected %h", m, INIT_M);
      end
      assertCount++;
      if (compute_done !== 1'b0) begin
         failCount++; $display("[TB] FAIL reset_done: got %b expected 0", compute_done);
      end
      assertCount++;
      if (m8 !== INIT_M) begin
         failCount++; $display("[TB] FAIL reset_m8: got %h expected %h", m8, INIT_M);
      end
      #9 reset_n = 1'b1;
      @(posedge clk); #1;
      mModel  = INIT_M;
      m8Model = INIT_M;
   endtask

   task automatic test_stream();
      int lat;
      logic [15:0] used;
      startRow(2, 2);
      sendBeat(0, 5);
      sendBeat(1, -3);
      sendBeat(5, 10);
      finishRow(lat, used);
      mModel[2]  = expBit(-6, used);
      m8Model[2] = expBit(-6, used);
      assertCount++;
      if (lat !== 2) begin
         failCount++; $display("[TB] FAIL stream_latency: got %0d expected 2", lat);
      end
      assertCount++;
      if (m !== mModel) begin
         failCount++; $display("[TB] FAIL stream_m: got %h expected %h", m, mModel);
      end
      assertCount++;
      if (m8 !== m8Model) begin
         failCount++; $display("[TB] FAIL stream_m8: got %h expected %h", m8, m8Model);
      end
      @(posedge clk); #1;
      assertCount++;
      if (compute_done !== 1'b0) begin
         failCount++; $display("[TB] FAIL stream_pulse_width: got %b expected 0", compute_done);
      end
   endtask

   task automatic test_overlap();
      int lat;
      logic [15:0] used;
      startRow(3, -128);
      data_valid = 1'b1;
      index      = 0;
      value      = 127;
      finishRow(lat, used);
      mModel[3]  = expBit(-1, used);
      m8Model[3] = expBit(-1, used);
      assertCount++;
      if (m !== mModel) begin
         failCount++; $display("[TB] FAIL overlap_m: got %h expected %h", m, mModel);
      end
      assertCount++;
      if (m8 !== m8Model) begin
         failCount++; $display("[TB] FAIL overlap_m8: got %h expected %h", m8, m8Model);
      end
   endtask

   task automatic test_row_oob();
      int lat;
      logic [15:0] used;
      startRow(16, 127);
      sendBeat(0, 1);
      finishRow(lat, used);
      assertCount++;
      if (lat !== 2) begin
         failCount++; $display("[TB] FAIL row_oob_latency: got %0d expected 2", lat);
      end
      assertCount++;
      if (m !== mModel) begin
         failCount++; $display("[TB] FAIL row_oob_m: got %h expected %h", m, mModel);
      end
   endtask

   task automatic test_empty_row();
      int lat;
      logic [15:0] used;
      startRow(4, 127);
      finishRow(lat, used);
      mModel[4]  = (used[7:0] != 8'h7F);
      m8Model[4] = (used[7:0] != 8'h7F);
      assertCount++;
      if (m !== mModel) begin
         failCount++; $display("[TB] FAIL empty_h127_m: got %h expected %h", m, mModel);
      end
      startRow(4, -128);
      finishRow(lat, used);
      mModel[4]  = 1'b0;
      m8Model[4] = 1'b0;
      assertCount++;
      if (m !== mModel) begin
         failCount++; $display("[TB] FAIL empty_hneg128_m: got %h expected %h", m, mModel);
      end
   endtask

   task automatic test_hold_load_done();
      int pulses;
      startRow(5, -128);
      load_done = 1'b1;
      @(posedge clk); #1;
      data_valid = 1'b1;
      index      = 0;
      value      = 127;
      pulses     = 0;
      for (int i = 0; i < 12; i++) begin
         if (compute_done === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      mModel[5]  = 1'b0;
      m8Model[5] = 1'b0;
      assertCount++;
      if (pulses !== 1) begin
         failCount++; $display("[TB] FAIL hold_pulses: got %0d expected 1", pulses);
      end
      assertCount++;
      if (m !== mModel) begin
         failCount++; $display("[TB] FAIL hold_m: got %h expected %h", m, mModel);
      end
      assertCount++;
      if (m8 !== m8Model) begin
         failCount++; $display("[TB] FAIL hold_m8: got %h expected %h", m8, m8Model);
      end
      data_valid = 1'b0;
   endtask

   task automatic test_reset_mid_row();
      int lat;
      logic [15:0] used;
      startRow(6, 0);
      sendBeat(0, 100);
      sendBeat(0, 100);
      sendBeat(1, 100);
      #2 reset_n = 1'b0;
      #1;
      assertCount++;
      if (m !== INIT_M) begin
         failCount++; $display("[TB] FAIL midreset_m: got %h expected %h", m, INIT_M);
      end
      assertCount++;
      if (compute_done !== 1'b0) begin
         failCount++; $display("[TB] FAIL midreset_done: got %b expected 0", compute_done);
      end
      mModel  = INIT_M;
      m8Model = INIT_M;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      startRow(6, 0);
      sendBeat(0, 10);
      finishRow(lat, used);
      mModel[6]  = expBit(10, used);
      m8Model[6] = expBit(10, used);
      assertCount++;
      if (lat !== 2) begin
         failCount++; $display("[TB] FAIL midreset_latency: got %0d expected 2", lat);
      end
      assertCount++;
      if (m !== mModel) begin
         failCount++; $display("[TB] FAIL midreset_next_m: got %h expected %h", m, mModel);
      end
   endtask

   task automatic test_acc_width8();
      int lat;
      logic [15:0] used;
      applyReset();
      startRow(8, 0);
      for (int i = 0; i < 20; i++) sendBeat(0, 100);
      finishRow(lat, used);
      mModel[8] = expBit(127, used);
`ifdef PBIT_ACC_SAT_EN
      m8Model[8] = expBit(127, used);
`else
      m8Model[8] = expBit(-48, used);
`endif
      assertCount++;
      if (m !== mModel) begin
         failCount++; $display("[TB] FAIL acc16_m: got %h expected %h", m, mModel);
      end
      assertCount++;
      if (m8 !== m8Model) begin
         failCount++; $display("[TB] FAIL acc8_m: got %h expected %h", m8, m8Model);
      end
   endtask

   // Rows are spaced 7 cycles apart so the draws walk the LFSR sequence with a stride coprime to its period.
   task automatic test_rate();
      int lat;
      logic [15:0] used;
      int ones127;
      int ones0;
      ones127 = 0;
      ones0   = 0;
      for (int i = 0; i < 1000; i++) begin
         startRow(9, 127);
         finishRow(lat, used);
         if (m[9] === 1'b1) ones127++;
         @(posedge clk); #1;
         @(posedge clk); #1;
      end
      for (int i = 0; i < 1000; i++) begin
         startRow(9, 0);
         finishRow(lat, used);
         if (m[9] === 1'b1) ones0++;
         @(posedge clk); #1;
         @(posedge clk); #1;
      end
      assertCount++;
      if (ones127 < 990) begin
         failCount++; $display("[TB] FAIL rate_act127: got %0d of 1000 expected >= 990", ones127);
      end
      assertCount++;
      if (ones0 < 450 || ones0 > 550) begin
         failCount++; $display("[TB] FAIL rate_act0: got %0d of 1000 expected 450..550", ones0);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_overlap();
      test_row_oob();
      test_empty_row();
      test_hold_load_done();
      test_reset_mid_row();
      test_acc_width8();
      test_rate();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
